intr_ctrl: RTL and testbench

Interrupt controller between the external interrupt lines and the MIPS core's exception logic.
- Captures single-cycle pulses on interrupts[7:0] and applies a software mask.
- Presents the highest-priority pending request to the core with an irq/irqack handshake, then holds that source in service until software writes end-of-interrupt (EOI).
- Software accesses a 4-word register window decoded by the top-level address map.

---
 rtl/intr_ctrl_pkg.sv | 30 +++
 rtl/intr_prio_enc.sv | 34 +++
 rtl/intr_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_intr_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl_pkg
// Description : Shared constants for the interrupt controller: register
//               window addresses, controller state encoding and the
//               default number of interrupt lines.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_ctrl_pkg;

    // Default number of interrupt lines (legal range 1..8)
    localparam int NUM_IRQ_DEFAULT = 8;

    // Source id width is fixed, independent of NUM_IRQ
    localparam int IRQID_W = 3;

    // Register window, word select
    localparam logic [1:0] ADR_PENDING = 2'd0;
    localparam logic [1:0] ADR_MASK    = 2'd1;
    localparam logic [1:0] ADR_CLAIM   = 2'd2;
    localparam logic [1:0] ADR_LEVEL   = 2'd3;

    // Controller state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t REQ     = 2'd1;
    localparam state_t SERVICE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/intr_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : intr_prio_enc
// Description : Combinational priority encoder. The lowest set index of
//               i_active wins. o_any flags that at least one bit is set.
// Ports       : i_active [NUM_IRQ] - active request vector
//               o_id     [3]       - index of highest-priority active bit
//               o_any    [1]       - any bit of i_active set
// Revision    : 1.0 - initial release
// ============================================================================
module intr_prio_enc
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
    input  logic [NUM_IRQ-1:0] i_active,
    output logic [IRQID_W-1:0] o_id,
    output logic               o_any
);

    // Scan from the top down so the last hit (lowest index) is kept
    always_comb begin
        o_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_active[i]) begin
                o_id = IRQID_W'(i);
            end
        end
    end

    assign o_any = |i_active;

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intr_ctrl
// Description : Interrupt controller in front of the core exception logic.
//               Captures rising edges on the interrupt lines, masks them,
//               requests the highest-priority source with an irq/irqack
//               handshake and holds it in service until software EOI.
//               Build option INTR_CTRL_LEVEL_EN adds a LEVEL register
//               (regadr 3) selecting level-sensitive lines; without it all
//               lines are edge-captured and regadr 3 reads as zero.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset
//               interrupts - raw interrupt lines
//               regadr     - 0 PENDING, 1 MASK, 2 CLAIM/EOI, 3 LEVEL
//               regwrite   - register write strobe
//               regread    - register read strobe
//               regwdata   - register write data
//               regrdata   - registered read data
//               irq        - interrupt request to core
//               irqack     - core acceptance pulse
//               irqid      - id of requested / in-service source
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupts,
    input  logic [1:0]         regadr,
    input  logic               regwrite,
    input  logic               regread,
    input  logic [DATA_W-1:0]  regwdata,
    output logic [DATA_W-1:0]  regrdata,
    output logic               irq,
    input  logic               irqack,
    output logic [IRQID_W-1:0] irqid
);

    state_t               r_state;
    state_t               w_state_d;
    logic [NUM_IRQ-1:0]   r_pending;
    logic [NUM_IRQ-1:0]   r_mask;
    logic [NUM_IRQ-1:0]   r_prev;
    logic [NUM_IRQ-1:0]   w_level;
    logic [NUM_IRQ-1:0]   w_pending_d;
    logic [NUM_IRQ-1:0]   w_edge;
    logic [NUM_IRQ-1:0]   w_pend_clr;
    logic [NUM_IRQ-1:0]   w_ack_clr;
    logic [NUM_IRQ-1:0]   w_active;
    logic [IRQID_W-1:0]   w_enc_id;
    logic                 w_any;
    logic                 w_ack;
    logic                 w_eoi;
    logic                 w_irq_d;
    logic [IRQID_W-1:0]   w_irqid_d;
    logic                 r_irq;
    logic [IRQID_W-1:0]   r_irqid;
    logic                 r_svc_valid;
    logic [IRQID_W-1:0]   r_svc_id;
    logic [DATA_W-1:0]    r_rdata;
    logic [DATA_W-1:0]    w_rdata;
    logic                 w_unused_wdata;

    // Write data above the implemented lines is ignored
    assign w_unused_wdata = ^regwdata[DATA_W-1:NUM_IRQ];

`ifdef INTR_CTRL_LEVEL_EN
    logic [NUM_IRQ-1:0] r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else if (regwrite && regadr == ADR_LEVEL) begin
            r_level <= regwdata[NUM_IRQ-1:0];
        end
    end

    assign w_level = r_level;
`else
    assign w_level = '0;
`endif

    // ------------------------------------------------------------------
    // Pending capture
    // ------------------------------------------------------------------
    assign w_edge     = interrupts & ~r_prev;
    assign w_pend_clr = (regwrite && regadr == ADR_PENDING) ? regwdata[NUM_IRQ-1:0] : '0;
    assign w_ack      = (r_state == REQ) && irqack;
    assign w_eoi      = (r_state == SERVICE) && regwrite && (regadr == ADR_CLAIM);
    // Acknowledge retires the source the core was actually shown (r_irqid)
    assign w_ack_clr  = w_ack ? (NUM_IRQ'(1) << r_irqid) : '0;

    // Edge lines: clears apply first, so a simultaneous new edge survives.
    // Level lines follow the input and ignore both kinds of clear.
    assign w_pending_d = (w_level & interrupts) |
                         (~w_level & ((r_pending & ~w_pend_clr & ~w_ack_clr) | w_edge));

    assign w_active = r_pending & r_mask;

    intr_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .i_active (w_active),
        .o_id     (w_enc_id),
        .o_any    (w_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_prev    <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= w_pending_d;
            r_prev    <= interrupts;
            if (regwrite && regadr == ADR_MASK) begin
                r_mask <= regwdata[NUM_IRQ-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_irq       <= 1'b0;
            r_irqid     <= '0;
            r_svc_valid <= 1'b0;
            r_svc_id    <= '0;
        end else begin
            r_state <= w_state_d;
            r_irq   <= w_irq_d;
            r_irqid <= w_irqid_d;
            if (w_ack) begin
                r_svc_valid <= 1'b1;
                r_svc_id    <= r_irqid;
            end else if (w_eoi) begin
                r_svc_valid <= 1'b0;
                r_svc_id    <= '0;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_any)  w_state_d = REQ;
            REQ: begin
                if (irqack)      w_state_d = SERVICE;
                else if (!w_any) w_state_d = IDLE;
            end
            SERVICE: if (w_eoi)  w_state_d = IDLE;
            default:             w_state_d = IDLE;
        endcase
    end

    // irqid holds its last value whenever no new request is being made,
    // so during service it keeps showing the in-service source.
    always_comb begin
        w_irq_d   = 1'b0;
        w_irqid_d = r_irqid;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_irq_d   = 1'b1;
                    w_irqid_d = w_enc_id;
                end
            end
            REQ: begin
                // Re-arbitrate each cycle until acknowledged
                if (!irqack && w_any) begin
                    w_irq_d   = 1'b1;
                    w_irqid_d = w_enc_id;
                end
            end
            default: w_irq_d = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register read-back (pre-write values on simultaneous access)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (regadr)
            ADR_PENDING: w_rdata = DATA_W'(r_pending);
            ADR_MASK:    w_rdata = DATA_W'(r_mask);
            ADR_CLAIM: begin
                w_rdata[DATA_W-1]    = r_svc_valid;
                w_rdata[IRQID_W-1:0] = r_svc_id;
            end
            ADR_LEVEL:   w_rdata = DATA_W'(w_level);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (regread) begin
            r_rdata <= w_rdata;
        end
    end

    assign regrdata = r_rdata;
    assign irq      = r_irq;
    assign irqid    = r_irqid;

endmodule
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_ctrl
// Description : Self-checking bench for intr_ctrl. A cycle-level model of
//               the controller rules runs alongside the DUT and is compared
//               every cycle; directed scenarios add literal expectations.
//               Build option INTR_CTRL_LEVEL_EN enables the level scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  interrupts = '0;
    logic [1:0]  regadr = '0;
    logic        regwrite = 1'b0;
    logic        regread = 1'b0;
    logic [31:0] regwdata = '0;
    logic [31:0] regrdata;
    logic        irq;
    logic        irqack = 1'b0;
    logic [2:0]  irqid;

    int n_pass  = 0;
    int n_total = 0;

    intr_ctrl #(.NUM_IRQ(8), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .interrupts (interrupts),
        .regadr     (regadr),
        .regwrite   (regwrite),
        .regread    (regread),
        .regwdata   (regwdata),
        .regrdata   (regrdata),
        .irq        (irq),
        .irqack     (irqack),
        .irqid      (irqid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: pending set, mask, "being requested" and
    // "in service" flags, updated from the rules at each clock edge.
    // ------------------------------------------------------------------
    logic [7:0]  m_pend, m_mask, m_prev, m_level;
    logic        m_req, m_svc, m_irq, m_cv, m_started;
    logic [2:0]  m_id, m_cid;
    logic [31:0] m_rdata;

    initial m_started = 1'b0;

    always @(posedge clk) begin : model
        logic [7:0] act, np;
        int best;
        logic ack, eoi;
        if (reset) begin
            m_pend = 0; m_mask = 0; m_prev = 0; m_level = 0;
            m_req = 0; m_svc = 0; m_irq = 0; m_cv = 0;
            m_id = 0; m_cid = 0; m_rdata = 0;
        end else begin
            act  = m_pend & m_mask;
            best = -1;
            for (int i = 7; i >= 0; i--) if (act[i]) best = i;
            ack = m_req && irqack;
            eoi = m_svc && regwrite && (regadr == 2'd2);
            if (regread) begin
                case (regadr)
                    2'd0: m_rdata = {24'b0, m_pend};
                    2'd1: m_rdata = {24'b0, m_mask};
                    2'd2: m_rdata = {m_cv, 28'b0, m_cid};
                    default: m_rdata = {24'b0, m_level};
                endcase
            end
            for (int i = 0; i < 8; i++) begin
                if (m_level[i]) np[i] = interrupts[i];
                else begin
                    np[i] = m_pend[i];
                    if (regwrite && regadr == 2'd0 && regwdata[i]) np[i] = 1'b0;
                    if (ack && int'(m_id) == i) np[i] = 1'b0;
                    if (interrupts[i] && !m_prev[i]) np[i] = 1'b1;
                end
            end
            if (m_svc) begin
                m_irq = 0;
                if (eoi) begin m_svc = 0; m_cv = 0; m_cid = 0; end
            end else if (m_req) begin
                if (ack) begin
                    m_req = 0; m_svc = 1; m_irq = 0; m_cv = 1; m_cid = m_id;
                end else if (best < 0) begin
                    m_req = 0; m_irq = 0;
                end else begin
                    m_irq = 1; m_id = 3'(best);
                end
            end else if (best >= 0) begin
                m_req = 1; m_irq = 1; m_id = 3'(best);
            end
            m_pend = np;
            m_prev = interrupts;
            if (regwrite && regadr == 2'd1) m_mask = regwdata[7:0];
`ifdef INTR_CTRL_LEVEL_EN
            if (regwrite && regadr == 2'd3) m_level = regwdata[7:0];
`endif
        end
        m_started = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_started) begin
            chk("cyc_irq",   {31'b0, irq},   {31'b0, m_irq});
            chk("cyc_irqid", {29'b0, irqid}, {29'b0, m_id});
            chk("cyc_rdata", regrdata,       m_rdata);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; inputs change on the falling edge
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] lines);
        interrupts = lines; tick(); interrupts = '0;
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] d);
        regadr = adr; regwdata = d; regwrite = 1'b1; tick();
        regwrite = 1'b0; regwdata = '0;
    endtask

    task automatic rd(input logic [1:0] adr, input string name, input logic [31:0] exp);
        regadr = adr; regread = 1'b1; tick(); regread = 1'b0;
        chk(name, regrdata, exp);
    endtask

    task automatic ack();
        irqack = 1'b1; tick(); irqack = 1'b0;
    endtask

    task automatic chk_irq(input string name, input logic exp_irq, input logic [2:0] exp_id);
        chk({name, "_irq"}, {31'b0, irq}, {31'b0, exp_irq});
        if (exp_irq) chk({name, "_id"}, {29'b0, irqid}, {29'b0, exp_id});
    endtask

    initial begin
        // 1: reset, single request, claim and EOI
        tick(2);
        chk("rst_irq",   {31'b0, irq},   32'd0);
        chk("rst_irqid", {29'b0, irqid}, 32'd0);
        chk("rst_rdata", regrdata,       32'd0);
        reset = 1'b0;
        wr(2'd1, 32'h0000_0003);
        pulse(8'h02);
        chk_irq("t1_before", 1'b0, 3'd0);
        tick();
        chk_irq("t1_req", 1'b1, 3'd1);
        ack();
        chk_irq("t1_ack", 1'b0, 3'd0);
        rd(2'd2, "t1_claim", 32'h8000_0001);
        wr(2'd2, 32'h0);
        rd(2'd2, "t1_claim_eoi", 32'h0);
        chk_irq("t1_after", 1'b0, 3'd0);

        // 2: simultaneous edges resolve lowest index first
        wr(2'd1, 32'hFFFF_FFFF);
        pulse(8'h24);
        tick();
        chk_irq("t2_first", 1'b1, 3'd2);
        ack();
        wr(2'd2, 32'h0);
        tick();
        chk_irq("t2_second", 1'b1, 3'd5);
        ack();
        wr(2'd2, 32'h0);
        rd(2'd0, "t2_pending", 32'h0);

        // 3: higher-priority source takes over before acknowledge
        pulse(8'h40);
        tick();
        chk_irq("t3_six", 1'b1, 3'd6);
        pulse(8'h01);
        chk_irq("t3_still6", 1'b1, 3'd6);
        tick();
        chk_irq("t3_zero", 1'b1, 3'd0);
        ack();
        rd(2'd0, "t3_pending", 32'h0000_0040);
        wr(2'd2, 32'h0);
        tick();
        chk_irq("t3_six_again", 1'b1, 3'd6);
        ack();
        wr(2'd2, 32'h0);

        // 4: masked source, enable, then withdraw by W1C
        wr(2'd1, 32'h0);
        pulse(8'h08);
        tick(2);
        chk_irq("t4_masked", 1'b0, 3'd0);
        rd(2'd0, "t4_pending", 32'h0000_0008);
        wr(2'd1, 32'h0000_0008);
        tick();
        chk_irq("t4_unmasked", 1'b1, 3'd3);
        wr(2'd0, 32'h0000_0008);
        tick();
        chk_irq("t4_withdrawn", 1'b0, 3'd0);
        rd(2'd0, "t4_pending_clr", 32'h0);

        // 5: same line re-fires during service; reset mid-service
        wr(2'd1, 32'h0000_00FF);
        pulse(8'h02);
        tick();
        chk_irq("t5_req", 1'b1, 3'd1);
        ack();
        pulse(8'h02);
        rd(2'd0, "t5_pending", 32'h0000_0002);
        tick(3);
        chk_irq("t5_hold", 1'b0, 3'd0);
        wr(2'd2, 32'h0);
        chk_irq("t5_eoi", 1'b0, 3'd0);
        tick();
        chk_irq("t5_rereq", 1'b1, 3'd1);
        ack();
        pulse(8'h04);
        rd(2'd2, "t5_claim", 32'h8000_0001);
        reset = 1'b1;
        tick();
        chk("t5_rst_irq",   {31'b0, irq},   32'd0);
        chk("t5_rst_irqid", {29'b0, irqid}, 32'd0);
        chk("t5_rst_rdata", regrdata,       32'd0);
        reset = 1'b0;
        rd(2'd0, "t5_rst_pending", 32'h0);
        rd(2'd1, "t5_rst_mask", 32'h0);
        rd(2'd2, "t5_rst_claim", 32'h0);
        tick(2);
        chk_irq("t5_rst_idle", 1'b0, 3'd0);

`ifdef INTR_CTRL_LEVEL_EN
        // 6: level-sensitive line
        wr(2'd3, 32'h0000_0001);
        wr(2'd1, 32'h0000_0001);
        interrupts = 8'h01;
        tick(2);
        chk_irq("t6_req", 1'b1, 3'd0);
        ack();
        rd(2'd0, "t6_pending", 32'h0000_0001);
        rd(2'd3, "t6_level", 32'h0000_0001);
        wr(2'd2, 32'h0);
        tick();
        chk_irq("t6_rereq", 1'b1, 3'd0);
        interrupts = 8'h00;
        tick(2);
        chk_irq("t6_drop", 1'b0, 3'd0);
        rd(2'd0, "t6_pending_drop", 32'h0);
`else
        // LEVEL register absent: writes ignored, reads zero
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, "t6_level_absent", 32'h0);
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
